// File: rtl/acc_alu.sv
// Sequential accumulator ALU: one command per valid/ready handshake, fixed-latency shift-add MUL.
// Optional clamp of arithmetic/MOV results to +/-SAT_LIMIT when SATURATE_EN is defined.
module acc_alu #(
  parameter int WIDTH     = 11,
  parameter int NOT_VALUE = 127,
  parameter int SAT_LIMIT = 999
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              funct,
  input  logic signed [WIDTH-1:0] operand,
  output logic signed [WIDTH-1:0] acc_out,
  output logic                    overflow,
  output logic                    gr_flag,
  output logic                    le_flag,
  output logic                    eq_flag,
  output logic                    busy,
  output logic                    done
);

  // Handshake: a command transfers on a rising edge where in_valid && in_ready;
  // in_ready is low only while a multiply runs, and nothing is queued meanwhile.

  localparam logic [3:0] F_ADD = 4'b1000;
  localparam logic [3:0] F_SUB = 4'b1001;
  localparam logic [3:0] F_MUL = 4'b1010;
  localparam logic [3:0] F_NOT = 4'b1011;
  localparam logic [3:0] F_MOV = 4'b0001;
  localparam logic [3:0] F_TLT = 4'b1110;
  localparam logic [3:0] F_TGT = 4'b1101;
  localparam logic [3:0] F_TEQ = 4'b1100;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic signed [2*WIDTH-1:0] SAT_HI = (2*WIDTH)'(SAT_LIMIT);
  localparam logic signed [2*WIDTH-1:0] SAT_LO = -SAT_HI;
`ifdef SATURATE_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state_q, state_d;

  logic signed [WIDTH-1:0] acc_q;
  logic                    ovf_q, gr_q, le_q, eq_q, done_q;
  logic [2*WIDTH-1:0]      prod_q, mcand_q;
  logic [WIDTH-1:0]        mplier_q;
  logic                    neg_q;
  logic [CW-1:0]           cnt_q;

  logic                    accept, mul_last;
  logic [WIDTH-1:0]        acc_mag, op_mag;
  logic signed [WIDTH:0]   sum_ext, diff_ext;
  logic [2*WIDTH-1:0]      prod_next, prod_signed;
  logic [WIDTH:0]          prod_upper;
  logic                    mul_ovf;
  logic signed [2*WIDTH-1:0] wide;
  logic                    wrap_ovf;
  logic signed [WIDTH-1:0] res;
  logic                    res_ovf;

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_MUL);
  assign accept   = in_valid && in_ready;
  assign mul_last = (state_q == S_MUL) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    if (accept && funct == F_MUL) state_d = S_MUL;
    else if (mul_last)            state_d = S_IDLE;
  end

  // Magnitudes as unsigned WIDTH-bit values so the most negative input maps to 2^(WIDTH-1).
  assign acc_mag = acc_q[WIDTH-1]   ? (~$unsigned(acc_q) + 1'b1)   : $unsigned(acc_q);
  assign op_mag  = operand[WIDTH-1] ? (~$unsigned(operand) + 1'b1) : $unsigned(operand);

  assign sum_ext  = {acc_q[WIDTH-1], acc_q} + {operand[WIDTH-1], operand};
  assign diff_ext = {acc_q[WIDTH-1], acc_q} - {operand[WIDTH-1], operand};

  assign prod_next   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_signed = neg_q ? (~prod_next + 1'b1) : prod_next;
  assign prod_upper  = prod_signed[2*WIDTH-1:WIDTH-1];
  assign mul_ovf     = !((&prod_upper) || (~|prod_upper));

  // True result widened to 2*WIDTH, then wrapped or clamped.
  always_comb begin
    wide     = '0;
    wrap_ovf = 1'b0;
    if (state_q == S_MUL) begin
      wide     = prod_signed;
      wrap_ovf = mul_ovf;
    end else begin
      case (funct)
        F_ADD: begin
          wide     = {{(WIDTH-1){sum_ext[WIDTH]}}, sum_ext};
          wrap_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
        end
        F_SUB: begin
          wide     = {{(WIDTH-1){diff_ext[WIDTH]}}, diff_ext};
          wrap_ovf = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
        end
        F_MOV:   wide = {{WIDTH{operand[WIDTH-1]}}, operand};
        default: wide = '0;
      endcase
    end
    res     = wide[WIDTH-1:0];
    res_ovf = wrap_ovf;
    if (SAT_ON) begin
      if (wide > SAT_HI) begin
        res     = SAT_HI[WIDTH-1:0];
        res_ovf = 1'b1;
      end else if (wide < SAT_LO) begin
        res     = SAT_LO[WIDTH-1:0];
        res_ovf = 1'b1;
      end else begin
        res_ovf = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      gr_q     <= 1'b0;
      le_q     <= 1'b0;
      eq_q     <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        done_q <= (funct != F_MUL);
        case (funct)
          F_ADD, F_SUB: begin
            acc_q <= res;
            ovf_q <= res_ovf;
          end
          F_MUL: begin
            prod_q   <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, acc_mag};
            mplier_q <= op_mag;
            neg_q    <= acc_q[WIDTH-1] ^ operand[WIDTH-1];
            cnt_q    <= '0;
          end
          F_NOT: begin
            acc_q <= (acc_q == '0) ? WIDTH'(NOT_VALUE) : '0;
            ovf_q <= 1'b0;
          end
          F_MOV: begin
            acc_q <= res;
            ovf_q <= 1'b0;
          end
          F_TLT, F_TGT, F_TEQ: begin
            gr_q <= (acc_q > operand);
            le_q <= (acc_q < operand);
            eq_q <= (acc_q == operand);
          end
          default: ovf_q <= 1'b0;
        endcase
      end else if (state_q == S_MUL) begin
        prod_q   <= prod_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (mul_last) begin
          acc_q  <= res;
          ovf_q  <= res_ovf;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign acc_out  = acc_q;
  assign overflow = ovf_q;
  assign gr_flag  = gr_q;
  assign le_flag  = le_q;
  assign eq_flag  = eq_q;
  assign done     = done_q;

endmodule

// File: tb/tb_acc_alu.sv
// Bench for acc_alu: directed steps then random commands against an integer reference model.
module tb_acc_alu;

  localparam int W       = 11;
  localparam int NOT_VAL = 127;
  localparam int SAT_LIM = 999;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [3:0] F_ADD = 4'b1000;
  localparam logic [3:0] F_SUB = 4'b1001;
  localparam logic [3:0] F_MUL = 4'b1010;
  localparam logic [3:0] F_NOT = 4'b1011;
  localparam logic [3:0] F_MOV = 4'b0001;
  localparam logic [3:0] F_TLT = 4'b1110;
  localparam logic [3:0] F_TGT = 4'b1101;
  localparam logic [3:0] F_TEQ = 4'b1100;

  logic                clk, reset, in_valid, in_ready;
  logic [3:0]          funct;
  logic signed [W-1:0] operand, acc_out;
  logic                overflow, gr_flag, le_flag, eq_flag, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_acc;
  bit m_ovf, m_gr, m_le, m_eq;

  acc_alu #(.WIDTH(W), .NOT_VALUE(NOT_VAL), .SAT_LIMIT(SAT_LIM)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .operand(operand), .acc_out(acc_out), .overflow(overflow),
    .gr_flag(gr_flag), .le_flag(le_flag), .eq_flag(eq_flag), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input longint v);
    longint m;
    m = v & ((64'sd1 <<< W) - 1);
    if (m >= (64'sd1 <<< (W - 1))) m = m - (64'sd1 <<< W);
    return int'(m);
  endfunction

  task automatic model_arith(input longint t, input bit is_mov);
    if (SAT && t > SAT_LIM) begin
      m_acc = SAT_LIM;  m_ovf = !is_mov;
    end else if (SAT && t < -SAT_LIM) begin
      m_acc = -SAT_LIM; m_ovf = !is_mov;
    end else begin
      m_acc = wrap(t);
      m_ovf = !is_mov && (longint'(m_acc) != t);
    end
  endtask

  task automatic model_apply(input logic [3:0] f, input int op);
    case (f)
      F_ADD: model_arith(longint'(m_acc) + longint'(op), 1'b0);
      F_SUB: model_arith(longint'(m_acc) - longint'(op), 1'b0);
      F_MUL: model_arith(longint'(m_acc) * longint'(op), 1'b0);
      F_MOV: model_arith(longint'(op), 1'b1);
      F_NOT: begin m_acc = (m_acc == 0) ? NOT_VAL : 0; m_ovf = 1'b0; end
      F_TLT, F_TGT, F_TEQ: begin
        m_gr = (m_acc > op); m_le = (m_acc < op); m_eq = (m_acc == op);
      end
      default: m_ovf = 1'b0;
    endcase
  endtask

  task automatic model_reset();
    m_acc = 0; m_ovf = 0; m_gr = 0; m_le = 0; m_eq = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".acc"}, $signed(acc_out), m_acc);
    check({tag, ".ovf"}, overflow, m_ovf);
    check({tag, ".gr"},  gr_flag,  m_gr);
    check({tag, ".le"},  le_flag,  m_le);
    check({tag, ".eq"},  eq_flag,  m_eq);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic send(input logic [3:0] f, input int op, input bit hold_valid, input string tag);
    int n;
    in_valid = 1'b1; funct = f; operand = W'(op);
    @(negedge clk);
    if (hold_valid) begin
      funct = F_ADD; operand = W'(5);
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    while (!done && n < 40) begin
      if (f == F_MUL) begin
        check({tag, ".busy"}, busy, 1);
        check({tag, ".in_ready"}, in_ready, 0);
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    model_apply(f, op);
    check({tag, ".latency"}, n, (f == F_MUL) ? W : 0);
    check({tag, ".busy_end"}, busy, 0);
    check_state(tag);
  endtask

  initial begin
    logic [3:0] ftab[10];
    logic [3:0] illegal[8];
    logic [3:0] f;
    int op;

    ftab    = '{F_ADD, F_SUB, F_MUL, F_NOT, F_MOV, F_TLT, F_TGT, F_TEQ, 4'b0000, F_MOV};
    illegal = '{4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1111};

    reset = 1'b1; in_valid = 1'b0; funct = 4'b0000; operand = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_state("reset");
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.in_ready", in_ready, 1);

    // wrapping add
    send(F_MOV, 500, 1'b0, "mov500");
    send(F_ADD, 600, 1'b0, "add600");
    check("add600.const_acc", $signed(acc_out), SAT ? 999 : -948);
    check("add600.const_ovf", overflow, 1);

    // multiply latency, in_valid held throughout, done width
    send(F_MOV, -7, 1'b0, "mov_m7");
    send(F_MUL, 13, 1'b1, "mul13");
    check("mul13.const_acc", $signed(acc_out), -91);
    @(negedge clk);
    check("mul13.done_width", done, 0);
    check("mul13.held", $signed(acc_out), -91);

    send(F_MOV, 100, 1'b0, "mov100");
    send(F_MUL, 100, 1'b0, "mul100");
    check("mul100.const_acc", $signed(acc_out), SAT ? 999 : -240);
    send(F_MOV, -1024, 1'b0, "mov_min");
    send(F_MUL, -1, 1'b0, "mul_m1");
    check("mul_m1.const_ovf", overflow, SAT ? 0 : 1);

    // compares
    send(F_MOV, -240, 1'b0, "mov_m240");
    send(F_TLT, 5, 1'b0, "tlt5");
    check("tlt5.const_le", le_flag, 1);
    send(F_TEQ, -240, 1'b0, "teq");
    check("teq.const_eq", eq_flag, 1);
    send(F_TGT, -300, 1'b0, "tgt");

    // NOT, illegal, zero-operand multiply
    send(F_MOV, 0, 1'b0, "mov0");
    send(F_NOT, 0, 1'b0, "not0");
    check("not0.const_acc", $signed(acc_out), 127);
    send(F_NOT, 0, 1'b0, "not1");
    send(F_MOV, 42, 1'b0, "mov42");
    send(4'b0000, 9, 1'b0, "illegal");
    send(F_MUL, 0, 1'b0, "mul_zero");

    // reset in the middle of a multiply
    send(F_MOV, 9, 1'b0, "mov9");
    in_valid = 1'b1; funct = F_MUL; operand = W'(4);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_state("mid_reset");
    check("mid_reset.busy", busy, 0);
    check("mid_reset.done", done, 0);
    check("mid_reset.in_ready", in_ready, 1);
    send(F_MOV, 3, 1'b0, "mov3");
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("post_reset.no_done", done, 0);
      check("post_reset.acc", $signed(acc_out), 3);
    end

    // random commands
    for (int i = 0; i < 200; i++) begin
      f = ftab[$urandom_range(0, 9)];
      if (f == 4'b0000) f = illegal[$urandom_range(0, 7)];
      op = wrap(longint'($urandom_range(0, (1 << W) - 1)));
      if ((f == F_TLT || f == F_TGT || f == F_TEQ) && $urandom_range(0, 3) == 0) op = m_acc;
      send(f, op, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
